control_mc2: RTL
================

// Module: control_mc2
// PURPOSE
//  Second-generation multicycle control FSM for the RV32I core. It sequences fetch, decode and
//  execute, and drives the datapath load/mux/ALU controls. New over the first generation:
//  held memory handshake with timeout, byte enables, and a trap path replacing dead-end error states.
//  Sits between the datapath and the memory port, and reuses the existing ir_decoder.
// PARAMETERS
//  MEM_TIMEOUT    255   cycles a request may wait for mem_resp; 0 = never time out
//  FENCE_AS_NOP   1     1: FENCE retires as a NOP; 0: FENCE raises an illegal-instruction trap
//  HALT_ON_EBREAK 1     1: EBREAK enters HALT; 0: EBREAK traps with cause 3
// PORTS
//  clk             in   1   clock
//  rst             in   1   asynchronous, active-high reset
//  ir              in   32  instruction register contents
//  bsr             in   3   branch status {eq, lt, ltu}
//  alu_lo          in   2   ALU result bits [1:0], used for alignment and byte lanes
//  mem_resp        in   1   memory completion; valid only while mem_read or mem_write is high
//  load_mar/pc/ir/mdr/reg out 1 datapath register loads
//  mdr_mux_sel     out  1   MDR source: 0 = memory, 1 = databus
//  rs1_mux_sel     out  rs1_mux_sel_t      ALU A source
//  rs2_mux_sel     out  rs2_mux_sel_t      ALU B source
//  databus_mux_sel out  databus_mux_sel_t  bus source; adds DATABUS_TRAPVEC
//  alu_op          out  4   ALU operation
//  mem_read        out  1   read request, held until mem_resp
//  mem_write       out  1   write request, held until mem_resp
//  mem_be          out  4   byte enables for the current access
//  rs1/rs2/rd      out  5   register indices from ir_decoder
//  immediate       out  32  decoded immediate
//  retire          out  1   one-cycle pulse when an instruction completes
//  trap            out  1   one-cycle pulse on trap entry
//  trap_cause      out  4   RISC-V mcause code of the last trap (registered)
//  halted          out  1   high while in HALT
// BEHAVIOUR
//  Reset: while rst is high, every load_*, mem_*, retire and trap output is forced to 0.
//   mem_be=0, trap_cause=0, halted=0, timeout counter=0, state=FETCH_0.
//   Reset mid-access drops mem_read/mem_write asynchronously.
//  Outputs are combinational from state except trap_cause, mem_be and the timeout counter.
//  Fetch:
//   - FETCH_0: MAR<-PC. mem_be<=4'hF.
//   - FETCH_1: hold mem_read. On mem_resp assert load_mdr in the same cycle and go to FETCH_2.
//   - FETCH_2: IR<-MDR.
//   - DECODE: dispatch on opcode.
//  Execute: LUI/AUIPC/REG_REG/REG_IMM write rd, then PC_INC. alu_op rules carry over unchanged.
//   BRANCH_0 goes to BRANCH_T or PC_INC on funct3/bsr; an invalid funct3 (010/011) traps illegal.
//   JAL_0/JALR_0 write rd=PC+4, then JAL_1/JALR_1 load the PC.
//  Load:
//   - LD_0: MAR<-rs1+imm; check alu_lo against funct3.
//   - Misaligned if half with alu_lo[0]=1, or word with alu_lo!=0. Misaligned load traps cause 4.
//   - Otherwise register mem_be: byte 4'b0001<<alu_lo, half 4'b0011<<alu_lo, word 4'hF.
//   - LD_1: hold mem_read; on mem_resp assert load_mdr.
//   - LD_2: RD<-MDR.
//  Store:
//   - ST_0: as LD_0; misaligned store traps cause 6.
//   - ST_1: MDR<-RS2 via databus (mdr_mux_sel=1, ALU_PASS_RS2).
//   - ST_2: hold mem_write until mem_resp, then PC_INC.
//  Retire: retire pulses in PC_INC, BRANCH_T, JAL_1 and JALR_1; never in TRAP.
//  Timeout:
//   - The counter clears on entering any request state and increments each cycle without mem_resp.
//   - When it equals MEM_TIMEOUT (if nonzero), drop the request next cycle and trap.
//   - Causes: fetch 1, load 5, store 7.
//   - mem_resp in the same cycle as the limit wins: the access completes.
//  Decode traps: unknown opcode, or FENCE with FENCE_AS_NOP=0, trap cause 2. ECALL traps cause 11.
//   EBREAK goes to HALT (HALT_ON_EBREAK=1) or traps cause 3.
//  TRAP (one cycle):
//   - Asserts load_pc with databus_mux_sel=DATABUS_TRAPVEC, plus the trap pulse.
//   - trap_cause is latched on entry; then FETCH_0.
//  HALT: halted=1; absorbing until rst.
// STRUCTURE
//  Package datatypes:
//   - Add DATABUS_TRAPVEC.
//   - Add trap_cause_t: FETCH_FAULT=1, ILLEGAL=2, BREAK=3, LD_MISALIGN=4, LD_FAULT=5,
//     ST_MISALIGN=6, ST_FAULT=7, ECALL=11.
//   - Add the state enum.
//  Instances: ir_decoder (existing), plus one new sub-module mem_watchdog, the parametrised
//   timeout counter with clear/enable/expired.
// TESTING
//  1. rst pulsed mid-FETCH_1 -> mem_read low the same cycle; after release, FETCH_0 with load_mar=1.
//  2. ADDI x1,x0,5 with 3-cycle mem latency -> mem_read held 3 cycles; one retire; rd write in REG_IMM.
//  3. LH with alu_lo=2 -> mem_be=4'b1100, no trap. LW with alu_lo=1 -> trap=1, trap_cause=4, no mem_read.
//  4. MEM_TIMEOUT=4, mem_resp never asserted on a store -> mem_write drops after 4 cycles; trap_cause=7.
//  5. ir=32'hFFFFFFFF -> trap_cause=2. EBREAK with HALT_ON_EBREAK=1 -> halted=1; stays until rst.
//  6. BNE with bsr=3'b000 -> BRANCH_T, retire=1. Branch funct3=3'b010 -> trap_cause=2.

Source files
------------

// File: rtl/control_mc2_pkg.sv
// Shared types for the second-generation multicycle control unit.
//   - RV32I opcode constants and ALU operation codes
//   - datapath mux select enums (databus gains DATABUS_TRAPVEC for trap entry)
//   - trap_cause_t: RISC-V mcause codes raised by the controller
//   - state_t: controller FSM states, plus helpers for request states and byte lanes
package control_mc2_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  // Codes {alt, funct3} map straight onto the ALU; the 1xxx holes carry the extras.
  localparam logic [3:0] ALU_ADD      = 4'b0000;
  localparam logic [3:0] ALU_SUB      = 4'b1000;
  localparam logic [3:0] ALU_PASS_RS1 = 4'b1110;
  localparam logic [3:0] ALU_PASS_RS2 = 4'b1111;

  localparam int unsigned TIMEOUT_W = 16;

  typedef enum logic [0:0] {RS1_SEL_RS1, RS1_SEL_PC} rs1_mux_sel_t;
  typedef enum logic [1:0] {RS2_SEL_RS2, RS2_SEL_IMM, RS2_SEL_FOUR} rs2_mux_sel_t;
  typedef enum logic [1:0] {DATABUS_ALU, DATABUS_MDR, DATABUS_TRAPVEC} databus_mux_sel_t;

  typedef enum logic [3:0] {
    TRAP_NONE   = 4'd0,
    FETCH_FAULT = 4'd1,
    ILLEGAL     = 4'd2,
    BREAK       = 4'd3,
    LD_MISALIGN = 4'd4,
    LD_FAULT    = 4'd5,
    ST_MISALIGN = 4'd6,
    ST_FAULT    = 4'd7,
    ECALL       = 4'd11
  } trap_cause_t;

  typedef enum logic [4:0] {
    StFetch0, StFetch1, StFetch2, StDecode,
    StLui, StAuipc, StRegReg, StRegImm, StPcInc,
    StBranch0, StBranchT, StJal0, StJal1, StJalr0, StJalr1,
    StLd0, StLd1, StLd2, StSt0, StSt1, StSt2,
    StTrap, StHalt
  } state_t;

  // States that hold a memory request open and are watched for timeout.
  function automatic logic is_req_state(input state_t s);
    return (s == StFetch1) || (s == StLd1) || (s == StSt2);
  endfunction

  // size: funct3[1:0] (00 byte, 01 half, 10 word).
  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/control_mc2_if.sv
// Memory request port between the control unit (master) and the memory (slave).
//   mem_read / mem_write : request, held until mem_resp
//   mem_be               : byte enables of the current access
//   mem_resp             : completion, meaningful only while a request is up
interface control_mc2_if;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_be;
  logic       mem_resp;

  modport master (output mem_read, output mem_write, output mem_be, input mem_resp);
  modport slave  (input mem_read, input mem_write, input mem_be, output mem_resp);
endinterface

// File: rtl/control_mc2_mem_watchdog.sv
// Memory request timeout counter.
//   clear   : restart the count (entering a request state)
//   enable  : a request is waiting this cycle without a response
//   expired : this is the LIMIT-th waiting cycle; the request must be abandoned
// LIMIT = 0 disables expiry. The count saturates so it never wraps into a false match.
module mem_watchdog
  import control_mc2_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  // count_q holds the waiting cycles already seen, so the LIMIT-th is count_q == LIMIT-1.
  assign expired = (LIMIT != 0) && enable && (32'(count_q) == LIMIT - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ir_decoder.sv
// Instruction field extraction and immediate generation.
//   ir        : instruction word
//   opcode    : ir[6:0];  funct3 : ir[14:12];  alt : ir[30] (SUB/SRA select)
//   rs1/rs2/rd: register indices
//   immediate : sign-extended immediate for the opcode's format
module ir_decoder
  import control_mc2_pkg::*;
(
  input  logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        alt,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] immediate
);

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign alt    = ir[30];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  always_comb begin
    immediate = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_STORE:         immediate = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        immediate = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: immediate = {ir[31:12], 12'b0};
      OP_JAL:           immediate = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          immediate = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

endmodule

// File: rtl/control_mc2.sv
// Multicycle control FSM for the RV32I core: fetch, decode, execute, with a held memory
// handshake plus timeout, byte enables and a single-cycle trap path.
//   clk, rst          : clock, asynchronous active-high reset
//   ir, bsr, alu_lo   : instruction, branch status {eq, lt, ltu}, ALU result [1:0]
//   mem               : memory request port (read/write/byte enables/response)
//   load_*            : datapath register loads
//   *_mux_sel, alu_op : datapath steering
//   rs1/rs2/rd/immediate : decoded fields
//   retire, trap      : one-cycle pulses; trap_cause holds the last trap code
//   halted            : high in HALT
module control_mc2
  import control_mc2_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter bit          FENCE_AS_NOP   = 1'b1,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic [2:0]       bsr,
  input  logic [1:0]       alu_lo,
  control_mc2_if.master    mem,
  output logic             load_mar,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_mdr,
  output logic             load_reg,
  output logic             mdr_mux_sel,
  output rs1_mux_sel_t     rs1_mux_sel,
  output rs2_mux_sel_t     rs2_mux_sel,
  output databus_mux_sel_t databus_mux_sel,
  output logic [3:0]       alu_op,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      immediate,
  output logic             retire,
  output logic             trap,
  output logic [3:0]       trap_cause,
  output logic             halted
);

  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        req_read, req_write;
  logic        wd_clear, wd_enable, wd_expired;
  logic        misaligned, size_bad, br_taken, br_bad;

  ir_decoder u_ir_decoder (
    .ir        (ir),
    .opcode    (opcode),
    .funct3    (funct3),
    .alt       (alt),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .immediate (immediate)
  );

  assign wd_clear  = is_req_state(state_d) && (state_d != state_q);
  assign wd_enable = is_req_state(state_q) && !mem.mem_resp;

  mem_watchdog #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign size_bad   = (funct3[1:0] == 2'b11);
  assign misaligned = ((funct3[1:0] == 2'b01) && alu_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_lo != 2'b00));

  always_comb begin
    br_bad   = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = bsr[2];
      3'b001:  br_taken = !bsr[2];
      3'b100:  br_taken = bsr[1];
      3'b101:  br_taken = !bsr[1];
      3'b110:  br_taken = bsr[0];
      3'b111:  br_taken = !bsr[0];
      default: br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cause_d         = TRAP_NONE;
    load_mar        = 1'b0;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_mdr        = 1'b0;
    load_reg        = 1'b0;
    mdr_mux_sel     = 1'b0;
    rs1_mux_sel     = RS1_SEL_RS1;
    rs2_mux_sel     = RS2_SEL_RS2;
    databus_mux_sel = DATABUS_ALU;
    alu_op          = ALU_ADD;
    req_read        = 1'b0;
    req_write       = 1'b0;
    retire          = 1'b0;
    trap            = 1'b0;

    case (state_q)
      StFetch0: begin
        load_mar    = 1'b1;
        rs1_mux_sel = RS1_SEL_PC;
        alu_op      = ALU_PASS_RS1;
        state_d     = StFetch1;
      end
      StFetch1: begin
        req_read = 1'b1;
        if (mem.mem_resp) begin
          load_mdr = 1'b1;
          state_d  = StFetch2;
        end else if (wd_expired) begin
          state_d = StTrap;
          cause_d = FETCH_FAULT;
        end
      end
      StFetch2: begin
        load_ir = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OP_LUI:      state_d = StLui;
          OP_AUIPC:    state_d = StAuipc;
          OP_OP:       state_d = StRegReg;
          OP_IMM:      state_d = StRegImm;
          OP_BRANCH:   state_d = StBranch0;
          OP_JAL:      state_d = StJal0;
          OP_JALR:     state_d = StJalr0;
          OP_LOAD:     state_d = StLd0;
          OP_STORE:    state_d = StSt0;
          OP_MISC_MEM: begin
            state_d = FENCE_AS_NOP ? StPcInc : StTrap;
            cause_d = FENCE_AS_NOP ? TRAP_NONE : ILLEGAL;
          end
          OP_SYSTEM: begin
            state_d = StTrap;
            if (ir == INSN_ECALL) begin
              cause_d = ECALL;
            end else if (ir == INSN_EBREAK) begin
              state_d = HALT_ON_EBREAK ? StHalt : StTrap;
              cause_d = HALT_ON_EBREAK ? TRAP_NONE : BREAK;
            end else begin
              cause_d = ILLEGAL;
            end
          end
          default: begin
            state_d = StTrap;
            cause_d = ILLEGAL;
          end
        endcase
      end
      StLui: begin
        rs2_mux_sel = RS2_SEL_IMM;
        alu_op      = ALU_PASS_RS2;
        load_reg    = 1'b1;
        state_d     = StPcInc;
      end
      StAuipc: begin
        rs1_mux_sel = RS1_SEL_PC;
        rs2_mux_sel = RS2_SEL_IMM;
        load_reg    = 1'b1;
        state_d     = StPcInc;
      end
      StRegReg: begin
        alu_op   = {alt, funct3};
        load_reg = 1'b1;
        state_d  = StPcInc;
      end
      StRegImm: begin
        // Only SRAI uses ir[30]; for other immediates it is just an immediate bit.
        rs2_mux_sel = RS2_SEL_IMM;
        alu_op      = {alt && (funct3 == 3'b101), funct3};
        load_reg    = 1'b1;
        state_d     = StPcInc;
      end
      StPcInc: begin
        rs1_mux_sel = RS1_SEL_PC;
        rs2_mux_sel = RS2_SEL_FOUR;
        load_pc     = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch0;
      end
      StBranch0: begin
        alu_op = ALU_SUB;
        if (br_bad) begin
          state_d = StTrap;
          cause_d = ILLEGAL;
        end else begin
          state_d = br_taken ? StBranchT : StPcInc;
        end
      end
      StBranchT, StJal1: begin
        rs1_mux_sel = RS1_SEL_PC;
        rs2_mux_sel = RS2_SEL_IMM;
        load_pc     = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch0;
      end
      StJal0, StJalr0: begin
        rs1_mux_sel = RS1_SEL_PC;
        rs2_mux_sel = RS2_SEL_FOUR;
        load_reg    = 1'b1;
        state_d     = (state_q == StJal0) ? StJal1 : StJalr1;
      end
      StJalr1: begin
        rs2_mux_sel = RS2_SEL_IMM;
        load_pc     = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch0;
      end
      StLd0, StSt0: begin
        rs2_mux_sel = RS2_SEL_IMM;
        load_mar    = 1'b1;
        if (size_bad) begin
          state_d = StTrap;
          cause_d = ILLEGAL;
        end else if (misaligned) begin
          state_d = StTrap;
          cause_d = (state_q == StLd0) ? LD_MISALIGN : ST_MISALIGN;
        end else begin
          state_d = (state_q == StLd0) ? StLd1 : StSt1;
        end
      end
      StLd1: begin
        req_read = 1'b1;
        if (mem.mem_resp) begin
          load_mdr = 1'b1;
          state_d  = StLd2;
        end else if (wd_expired) begin
          state_d = StTrap;
          cause_d = LD_FAULT;
        end
      end
      StLd2: begin
        databus_mux_sel = DATABUS_MDR;
        load_reg        = 1'b1;
        state_d         = StPcInc;
      end
      StSt1: begin
        alu_op      = ALU_PASS_RS2;
        mdr_mux_sel = 1'b1;
        load_mdr    = 1'b1;
        state_d     = StSt2;
      end
      StSt2: begin
        req_write = 1'b1;
        if (mem.mem_resp) begin
          state_d = StPcInc;
        end else if (wd_expired) begin
          state_d = StTrap;
          cause_d = ST_FAULT;
        end
      end
      StTrap: begin
        databus_mux_sel = DATABUS_TRAPVEC;
        load_pc         = 1'b1;
        trap            = 1'b1;
        state_d         = StFetch0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch0;
    endcase

    // Reset parks the FSM in FETCH_0, whose outputs must stay quiet until release.
    if (rst) begin
      load_mar  = 1'b0;
      load_pc   = 1'b0;
      load_ir   = 1'b0;
      load_mdr  = 1'b0;
      load_reg  = 1'b0;
      req_read  = 1'b0;
      req_write = 1'b0;
      retire    = 1'b0;
      trap      = 1'b0;
    end
  end

  always_comb begin
    mem_be_d = mem_be_q;
    if (state_q == StFetch0) begin
      mem_be_d = 4'hF;
    end else if (((state_q == StLd0) || (state_q == StSt0)) && !size_bad && !misaligned) begin
      mem_be_d = byte_lanes(funct3[1:0], alu_lo);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch0;
      cause_q  <= TRAP_NONE;
      mem_be_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      mem_be_q <= mem_be_d;
      if (state_d == StTrap) begin
        cause_q <= cause_d;
      end
    end
  end

  assign mem.mem_read  = req_read;
  assign mem.mem_write = req_write;
  assign mem.mem_be    = mem_be_q;
  assign trap_cause    = cause_q;
  assign halted        = (state_q == StHalt);

endmodule
